bp_be_accel_ws_xor_core: RTL
============================

// Module: bp_be_accel_ws_xor_core
// PURPOSE
//  Weight-stationary XOR compute core of the BE accelerator pipe. Consumes paired (op, cache block) tokens
//  popped from the accel op/data FIFOs, holds two weight banks, and XORs activation blocks against a bank.
//  Serializes each result block as fill-width beats into the accel panic two-FIFO ahead of the mem_fwd stream pump.
// PARAMETERS
//  block_width_p  512  width of one dcache block token on data_i (dcache_block_width_p)
//  fill_width_p   128  width of one output beat (bedrock_fill_width_p); block_width_p % fill_width_p == 0
//  beats_lp      (localparam) block_width_p/fill_width_p; beat counter width `BSG_SAFE_CLOG2(beats_lp)
// PORTS
//  clk_i         in   1              sole clock; all state updates on posedge
//  reset_n_i     in   1              synchronous, active-low reset
//  op_i          in   2              bp_be_accel_op_e: 00 ACLD0, 01 ACLD1, 10 WTLD0, 11 WTLD1
//  data_i        in   block_width_p  activation or weight block
//  v_i           in   1              token valid
//  ready_o       out  1              core accepts a token this cycle; transfer = v_i & ready_o
//  data_o        out  fill_width_p   result beat
//  v_o           out  1              beat valid
//  yumi_i        in   1              consumer takes beat; legal only while v_o
//  perf_tokens_o out  32             [BP_BE_ACCEL_PERF_EN only] accepted ACLD tokens
//  perf_stall_o  out  32             [BP_BE_ACCEL_PERF_EN only] cycles with v_o & ~yumi_i
// BEHAVIOUR
//  Reset (reset_n_i==0 at posedge): state e_idle, both weight banks '0, result reg '0, beat cnt 0,
//   perf counters 0; outputs: ready_o=1, v_o=0, data_o='0.
//  States: e_idle (no result pending), e_drain (result reg holds block, beats pending).
//  WTLDk accepted (op_i[1]=1): weight bank k <= data_i on the accepting edge; state unchanged; 1-cycle.
//   Does not disturb an in-flight drain.
//  ACLDk accepted (op_i[1]=0): result <= data_i ^ bank[op_i[0]] using the bank value before this edge.
//   A WTLD to the same bank is never accepted on the same edge (one token/cycle). Next: e_drain, cnt 0.
//  e_drain: v_o=1, data_o = result[cnt*fill_width_p +: fill_width_p] (beat 0 = LSBs).
//   yumi_i & cnt<beats_lp-1: cnt++. yumi_i & cnt==beats_lp-1: last beat; cnt<=0.
//  ready_o = (state==e_idle) | (state==e_drain & yumi_i & cnt==beats_lp-1) | (state==e_drain & op_i[1]).
//   WTLD is accepted during drain. Back-to-back ACLD on the last-beat yumi: result reloads, state stays
//   e_drain, so there are zero bubble cycles between blocks.
//  Last beat yumi with no new ACLD accepted: state -> e_idle.
//  Latency: ACLD accepted at edge N -> beat 0 valid in cycle N+1. Beats hold stable while ~yumi_i.
//  beats_lp==1: every yumi is the last beat; cnt is constant 0.
//  v_i low: no state change except drain progress. ready_o does not depend on v_i.
//  Reset mid-drain: pending beats are discarded and weights cleared. Upstream FIFOs own token recovery.
// CONFIGURATION
//  `BP_BE_ACCEL_PERF_EN defined: perf_tokens_o/perf_stall_o ports exist. Both saturate at 32'hFFFF_FFFF
//   and clear on reset only.
//  Not defined: ports and counters are absent; functional behaviour is identical.
// STRUCTURE
//  bp_be_pkg: typedef enum logic [1:0] bp_be_accel_op_e {e_accel_acld0, e_accel_acld1, e_accel_wtld0,
//   e_accel_wtld1}; typedef enum logic {e_idle, e_drain} bp_be_accel_core_state_e.
//  Sub-module bp_be_accel_ws_bank: two block_width_p weight regs with write-enable/select and a
//   combinational read select.
//  Beat counter: bsg_counter_clear_up. Beat mux: indexed part-select. No other sub-modules.
// TESTING (block 512, fill 128, beats 4)
//  1 Reset: hold reset_n_i=0 for 3 cycles -> ready_o=1, v_o=0, data_o=0. ACLD0 of all-ones -> 4 beats of
//    128'hFF..F (banks are 0).
//  2 WTLD0 {4{128'hA5..A5}}, then ACLD0 {4{128'hFF..F}} -> beats 0..3 = 128'h5A..5A. ACLD1 same data ->
//    beats = FF..F (bank1 untouched).
//  3 ACLD0 with beat b = 128'(b+1); yumi_i low 5 cycles after beat 1 -> data_o holds beat 1 stable, then
//    order 1,2,3,4 with no repeats or drops.
//  4 Continuous v_i ACLD stream with yumi_i=1 -> one beat every cycle, ready_o pulses on each 4th beat,
//    8 blocks in 32+1 cycles.
//  5 WTLD1 issued during drain of an ACLD1 -> current beats use the old bank1; the next ACLD1 uses the new
//    one. Drain is not stalled.
//  6 Deassert reset_n_i during beat 2 of a drain -> next cycle v_o=0, ready_o=1; next ACLD0 XORs with 0.
//    With PERF_EN: tokens=0 after reset, stall counts the test-3 wait as 5.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared types for the BE accelerator XOR core: op encoding, core state
// enum and a small sizing helper used for counter widths.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_accel_acld0 = 2'b00,
    e_accel_acld1 = 2'b01,
    e_accel_wtld0 = 2'b10,
    e_accel_wtld1 = 2'b11
  } bp_be_accel_op_e;

  typedef enum logic {
    e_idle  = 1'b0,
    e_drain = 1'b1
  } bp_be_accel_core_state_e;

  // Counter width that stays at least one bit when only one value is needed
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_be_accel_ws_bank.sv
// Two stationary weight registers with a single write port and a
// combinational read select. A read in the same cycle as a write to the
// same bank returns the value held before the edge.
module bp_be_accel_ws_bank #(
  parameter int width_p = 512
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               we_i,
  input  logic               w_sel_i,
  input  logic [width_p-1:0] w_data_i,
  input  logic               r_sel_i,
  output logic [width_p-1:0] r_data_o
);

  logic [width_p-1:0] bank0_r;
  logic [width_p-1:0] bank1_r;

  // Load the selected weight bank; both banks clear on reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      bank0_r <= '0;
      bank1_r <= '0;
    end else if (we_i) begin
      if (w_sel_i)
        bank1_r <= w_data_i;
      else
        bank0_r <= w_data_i;
    end
  end

  assign r_data_o = r_sel_i ? bank1_r : bank0_r;

endmodule

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear takes priority over count-up.
module bsg_counter_clear_up #(
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  // Reset or clear returns to zero, otherwise advance by one when asked
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i)
      count_o <= '0;
    else if (up_i)
      count_o <= count_o + width_p'(1);
  end

endmodule

// File: rtl/bp_be_accel_ws_xor_core.sv
// Weight-stationary XOR core. Weight loads (WTLDk) fill bank k; activation
// loads (ACLDk) XOR the block against bank k and the result is drained as
// fill-width beats, LSB beat first. A new ACLD is taken on the last-beat
// handshake so consecutive blocks stream with no bubble, and weight loads
// are taken during a drain without disturbing it.
// Optional build macro: BP_BE_ACCEL_PERF_EN adds saturating perf counters
// for accepted ACLD tokens and stalled output cycles.
module bp_be_accel_ws_xor_core
  import bp_be_pkg::*;
#(
  parameter int block_width_p = 512,
  parameter int fill_width_p  = 128
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [1:0]               op_i,
  input  logic [block_width_p-1:0] data_i,
  input  logic                     v_i,
  output logic                     ready_o,
  output logic [fill_width_p-1:0]  data_o,
  output logic                     v_o,
  input  logic                     yumi_i
`ifdef BP_BE_ACCEL_PERF_EN
  ,
  output logic [31:0]              perf_tokens_o,
  output logic [31:0]              perf_stall_o
`endif
);

  localparam int beats_lp     = block_width_p / fill_width_p;
  localparam int cnt_width_lp = safe_clog2(beats_lp);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(beats_lp - 1);

  bp_be_accel_core_state_e state_r, state_n;
  bp_be_accel_op_e         op;
  logic                    is_wtld;
  logic                    draining;
  logic                    last_beat;
  logic                    accept;
  logic                    acld_acc;
  logic                    wtld_acc;
  logic [cnt_width_lp-1:0] cnt;
  logic [block_width_p-1:0] bank_rd;
  logic [block_width_p-1:0] result_r;

  assign op        = bp_be_accel_op_e'(op_i);
  assign is_wtld   = (op == e_accel_wtld0) || (op == e_accel_wtld1);
  assign draining  = (state_r == e_drain);
  assign last_beat = draining && yumi_i && (cnt == last_cnt_lp);
  assign ready_o   = !draining || last_beat || (draining && is_wtld);
  assign accept    = v_i && ready_o;
  assign acld_acc  = accept && !is_wtld;
  assign wtld_acc  = accept && is_wtld;

  bp_be_accel_ws_bank #(
    .width_p(block_width_p)
  ) bank (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .we_i     (wtld_acc),
    .w_sel_i  (op_i[0]),
    .w_data_i (data_i),
    .r_sel_i  (op_i[0]),
    .r_data_o (bank_rd)
  );

  bsg_counter_clear_up #(
    .width_p(cnt_width_lp)
  ) beat_counter (
    .clk_i  (clk_i),
    .reset_i(!reset_n_i),
    .clear_i(acld_acc || last_beat),
    .up_i   (draining && yumi_i && !last_beat),
    .count_o(cnt)
  );

  // State register and result block capture on an accepted ACLD
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r  <= e_idle;
      result_r <= '0;
    end else begin
      state_r <= state_n;
      if (acld_acc)
        result_r <= data_i ^ bank_rd;
    end
  end

  // Next state: a new ACLD (re)starts a drain, a bare last beat ends it
  always_comb begin
    state_n = state_r;
    if (acld_acc)
      state_n = e_drain;
    else if (last_beat)
      state_n = e_idle;
  end

  assign v_o    = draining;
  assign data_o = draining ? result_r[cnt * fill_width_p +: fill_width_p] : '0;

`ifdef BP_BE_ACCEL_PERF_EN
  // Saturating counts of accepted ACLD tokens and back-pressured beats
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      perf_tokens_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (acld_acc && (perf_tokens_o != 32'hFFFF_FFFF))
        perf_tokens_o <= perf_tokens_o + 32'd1;
      if (v_o && !yumi_i && (perf_stall_o != 32'hFFFF_FFFF))
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule
